// File: rtl/tx_fsm.sv
// tx_fsm: request-side issue stage. Decodes a host address into a switch instance and register offset and issues one-cycle select pulses.
// Optional decode-error response port dec_err is present when TX_ERR_RESP_EN is defined.
module tx_fsm #(
    parameter int NUM_SW_INST = 5,
    parameter int W_WIDTH     = 8,
    parameter int A_WIDTH     = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic [A_WIDTH-1:0]     req_addr,
    input  logic                   req_wr,
    input  logic [W_WIDTH-1:0]     req_wdata,
    input  logic [7:0]             req_op_id,
    input  logic [NUM_SW_INST-1:0] sw_busy,
    output logic [NUM_SW_INST-1:0] sel_en,
    output logic [7:0]             op_id,
    output logic [3:0]             sw_addr,
    output logic                   sw_wr,
    output logic [W_WIDTH-1:0]     sw_wdata
`ifdef TX_ERR_RESP_EN
    ,
    output logic                   dec_err
`endif
);

    localparam int IDX_W = A_WIDTH - 4;
    localparam int SEL_W = (NUM_SW_INST > 1) ? $clog2(NUM_SW_INST) : 1;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_HOLD = 1'b1;

    logic [0:0]             state;
    logic [SEL_W-1:0]       cap_idx;
    logic [3:0]             cap_off;
    logic                   cap_wr;
    logic [W_WIDTH-1:0]     cap_wdata;
    logic [7:0]             cap_op;
    logic                   cap_bad;
    logic [NUM_SW_INST-1:0] shadow;

    logic [IDX_W-1:0]       idx_field;
    logic                   req_bad;
    logic                   blocked;
    logic [NUM_SW_INST-1:0] one_hot;

    assign idx_field = req_addr[A_WIDTH-1:4];

    // Compare at 32 bits so NUM_SW_INST == 2**IDX_W does not truncate to zero.
    assign req_bad = (32'(idx_field) >= 32'(NUM_SW_INST)) || (req_op_id == 8'h00);

    assign blocked = sw_busy[cap_idx] | shadow[cap_idx];

    always_comb begin
        one_hot = '0;
        for (int unsigned i = 0; i < NUM_SW_INST; i++) begin
            one_hot[i] = (cap_idx == SEL_W'(i));
        end
    end

    assign req_ready = rst_n & (state == ST_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            cap_idx   <= '0;
            cap_off   <= '0;
            cap_wr    <= 1'b0;
            cap_wdata <= '0;
            cap_op    <= '0;
            cap_bad   <= 1'b0;
            shadow    <= '0;
            sel_en    <= '0;
            op_id     <= '0;
            sw_addr   <= '0;
            sw_wr     <= 1'b0;
            sw_wdata  <= '0;
`ifdef TX_ERR_RESP_EN
            dec_err   <= 1'b0;
`endif
        end else begin
            sel_en <= '0;
            shadow <= sel_en;
`ifdef TX_ERR_RESP_EN
            dec_err <= 1'b0;
`endif
            if (state == ST_IDLE) begin
                if (req_valid) begin
                    cap_idx   <= idx_field[SEL_W-1:0];
                    cap_off   <= req_addr[3:0];
                    cap_wr    <= req_wr;
                    cap_wdata <= req_wdata;
                    cap_op    <= req_op_id;
                    cap_bad   <= req_bad;
                    state     <= ST_HOLD;
                end
            end else begin
                if (cap_bad) begin
`ifdef TX_ERR_RESP_EN
                    dec_err <= 1'b1;
                    op_id   <= cap_op;
`endif
                    state <= ST_IDLE;
                end else if (!blocked) begin
                    sel_en   <= one_hot;
                    op_id    <= cap_op;
                    sw_addr  <= cap_off;
                    sw_wr    <= cap_wr;
                    sw_wdata <= cap_wdata;
                    state    <= ST_IDLE;
                end
            end
        end
    end

endmodule

// File: tb/tb_tx_fsm.sv
// tb_tx_fsm: directed self-checking bench for tx_fsm with hand-computed expectations.
// Covers both builds; dec_err checks apply when TX_ERR_RESP_EN is defined.
module tb_tx_fsm;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req_valid;
    logic       req_ready;
    logic [7:0] req_addr;
    logic       req_wr;
    logic [7:0] req_wdata;
    logic [7:0] req_op_id;
    logic [4:0] sw_busy;
    logic [4:0] sel_en;
    logic [7:0] op_id;
    logic [3:0] sw_addr;
    logic       sw_wr;
    logic [7:0] sw_wdata;
`ifdef TX_ERR_RESP_EN
    logic       dec_err;
`endif

    int total = 0;
    int bad   = 0;
    logic [7:0] last_op;

    tx_fsm #(.NUM_SW_INST(5), .W_WIDTH(8), .A_WIDTH(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .req_wr    (req_wr),
        .req_wdata (req_wdata),
        .req_op_id (req_op_id),
        .sw_busy   (sw_busy),
        .sel_en    (sel_en),
        .op_id     (op_id),
        .sw_addr   (sw_addr),
        .sw_wr     (sw_wr),
        .sw_wdata  (sw_wdata)
`ifdef TX_ERR_RESP_EN
        ,
        .dec_err   (dec_err)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive_req(input logic [7:0] a, input logic w, input logic [7:0] d, input logic [7:0] op);
        req_valid = 1'b1;
        req_addr  = a;
        req_wr    = w;
        req_wdata = d;
        req_op_id = op;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        req_valid = 1'b0; req_addr = '0; req_wr = 1'b0; req_wdata = '0; req_op_id = '0; sw_busy = '0;
        tick; tick;
        total++; if (req_ready !== 1'b0) begin bad++; $display("FAIL reset_ready got=%b exp=0", req_ready); end
        total++; if (sel_en !== 5'b0) begin bad++; $display("FAIL reset_sel got=%b exp=00000", sel_en); end
        total++; if ({op_id, sw_addr, sw_wr, sw_wdata} !== 21'h0) begin bad++; $display("FAIL reset_payload got=%h/%h/%b/%h exp=0", op_id, sw_addr, sw_wr, sw_wdata); end
`ifdef TX_ERR_RESP_EN
        total++; if (dec_err !== 1'b0) begin bad++; $display("FAIL reset_dec_err got=%b exp=0", dec_err); end
`endif
        rst_n = 1'b1;
        tick;
        total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL reset_release_ready got=%b exp=1", req_ready); end
        last_op = 8'h00;
    endtask

    task automatic test_basic_read;
        sw_busy = '0;
        drive_req(8'h23, 1'b0, 8'h00, 8'h11);
        tick;
        req_valid = 1'b0;
        total++; if (req_ready !== 1'b0) begin bad++; $display("FAIL read_hold_ready got=%b exp=0", req_ready); end
        total++; if (sel_en !== 5'b0) begin bad++; $display("FAIL read_early_sel got=%b exp=00000", sel_en); end
        tick;
        total++; if (sel_en !== 5'b00100) begin bad++; $display("FAIL read_sel got=%b exp=00100", sel_en); end
        total++; if (sw_addr !== 4'h3) begin bad++; $display("FAIL read_sw_addr got=%h exp=3", sw_addr); end
        total++; if (op_id !== 8'h11) begin bad++; $display("FAIL read_op_id got=%h exp=11", op_id); end
        total++; if (sw_wr !== 1'b0) begin bad++; $display("FAIL read_sw_wr got=%b exp=0", sw_wr); end
        total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL read_ready_back got=%b exp=1", req_ready); end
        tick;
        total++; if (sel_en !== 5'b0) begin bad++; $display("FAIL read_pulse_len got=%b exp=00000", sel_en); end
        total++; if (op_id !== 8'h11) begin bad++; $display("FAIL read_op_hold got=%h exp=11", op_id); end
        last_op = 8'h11;
    endtask

    task automatic test_other_busy;
        sw_busy = 5'b11110;
        drive_req(8'h05, 1'b0, 8'h00, 8'h21);
        tick;
        req_valid = 1'b0;
        tick;
        total++; if (sel_en !== 5'b00001) begin bad++; $display("FAIL other_busy_sel got=%b exp=00001", sel_en); end
        total++; if (op_id !== 8'h21) begin bad++; $display("FAIL other_busy_op got=%h exp=21", op_id); end
        sw_busy = '0;
        tick;
        last_op = 8'h21;
    endtask

    task automatic test_blocked;
        sw_busy = 5'b10000;
        drive_req(8'h4A, 1'b1, 8'hA5, 8'h07);
        tick;
        req_valid = 1'b0;
        total++; if ({req_ready, sel_en} !== 6'b0) begin bad++; $display("FAIL blocked_c1 got=ready %b sel %b exp=0/00000", req_ready, sel_en); end
        for (int i = 0; i < 5; i++) begin
            tick;
            total++; if ({req_ready, sel_en} !== 6'b0) begin bad++; $display("FAIL blocked_hold%0d got=ready %b sel %b exp=0/00000", i, req_ready, sel_en); end
        end
        sw_busy = '0;
        tick;
        total++; if (sel_en !== 5'b10000) begin bad++; $display("FAIL blocked_sel got=%b exp=10000", sel_en); end
        total++; if (sw_wdata !== 8'hA5) begin bad++; $display("FAIL blocked_wdata got=%h exp=a5", sw_wdata); end
        total++; if ({sw_wr, sw_addr, op_id} !== {1'b1, 4'hA, 8'h07}) begin bad++; $display("FAIL blocked_payload got=%b/%h/%h exp=1/a/07", sw_wr, sw_addr, op_id); end
        tick;
        total++; if (sel_en !== 5'b0) begin bad++; $display("FAIL blocked_pulse_len got=%b exp=00000", sel_en); end
        last_op = 8'h07;
    endtask

    task automatic test_back_to_back;
        int pulses = 0;
        int c1 = -1;
        int c2 = -1;
        int busy_left = 0;
        logic rise_next = 1'b0;
        logic rose = 1'b0;
        logic fell = 1'b0;
        int sent = 1;
        sw_busy = '0;
        drive_req(8'h10, 1'b0, 8'h00, 8'h01);
        for (int c = 1; c <= 30; c++) begin
            tick;
            if (req_valid) req_valid = 1'b0;
            if (busy_left > 0) begin
                busy_left--;
                if (busy_left == 0) sw_busy[1] = 1'b0;
            end
            if (rise_next) begin
                sw_busy[1] = 1'b1;
                busy_left = 4;
                rise_next = 1'b0;
            end
            if (pulses >= 1 && sw_busy[1]) rose = 1'b1;
            if (rose && !sw_busy[1]) fell = 1'b1;
            if (sel_en != 5'b0) begin
                pulses++;
                rise_next = 1'b1;
                total++; if (sel_en !== 5'b00010) begin bad++; $display("FAIL b2b_sel got=%b exp=00010", sel_en); end
                if (pulses == 1) begin
                    c1 = c;
                    total++; if (op_id !== 8'h01) begin bad++; $display("FAIL b2b_op1 got=%h exp=01", op_id); end
                end else if (pulses == 2) begin
                    c2 = c;
                    total++; if (op_id !== 8'h02 || sw_addr !== 4'h2) begin bad++; $display("FAIL b2b_op2 got=%h/%h exp=02/2", op_id, sw_addr); end
                    total++; if (!(rose && fell)) begin bad++; $display("FAIL b2b_busy_cycle got=rose %b fell %b exp=1/1", rose, fell); end
                end
            end
            if (sent < 2 && pulses >= 1 && req_ready) begin
                drive_req(8'h12, 1'b0, 8'h00, 8'h02);
                sent = 2;
            end
        end
        total++; if (pulses !== 2) begin bad++; $display("FAIL b2b_count got=%0d exp=2", pulses); end
        total++; if (c1 !== 2 || c2 !== 8) begin bad++; $display("FAIL b2b_timing got=%0d/%0d exp=2/8", c1, c2); end
        sw_busy = '0;
        last_op = 8'h02;
    endtask

    task automatic test_shadow_gap;
        sw_busy = '0;
        tick;
        drive_req(8'h11, 1'b0, 8'h00, 8'h03);
        tick;
        req_valid = 1'b0;
        tick;
        total++; if (sel_en !== 5'b00010) begin bad++; $display("FAIL shadow_first got=%b exp=00010", sel_en); end
        drive_req(8'h13, 1'b0, 8'h00, 8'h04);
        tick;
        req_valid = 1'b0;
        total++; if (sel_en !== 5'b0) begin bad++; $display("FAIL shadow_gap1 got=%b exp=00000", sel_en); end
        tick;
        total++; if (sel_en !== 5'b0 || req_ready !== 1'b0) begin bad++; $display("FAIL shadow_gap2 got=sel %b ready %b exp=00000/0", sel_en, req_ready); end
        tick;
        total++; if (sel_en !== 5'b00010 || op_id !== 8'h04) begin bad++; $display("FAIL shadow_second got=%b/%h exp=00010/04", sel_en, op_id); end
        tick;
        last_op = 8'h04;
    endtask

    task automatic test_invalid;
        logic [7:0] addrs [2];
        logic [7:0] ops   [2];
        addrs[0] = 8'h50; ops[0] = 8'h09;
        addrs[1] = 8'h00; ops[1] = 8'h00;
        sw_busy = '0;
        for (int k = 0; k < 2; k++) begin
            drive_req(addrs[k], 1'b0, 8'h00, ops[k]);
            tick;
            req_valid = 1'b0;
            total++; if (req_ready !== 1'b0 || sel_en !== 5'b0) begin bad++; $display("FAIL inv%0d_c1 got=ready %b sel %b exp=0/00000", k, req_ready, sel_en); end
            tick;
            total++; if (sel_en !== 5'b0) begin bad++; $display("FAIL inv%0d_sel got=%b exp=00000", k, sel_en); end
            total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL inv%0d_ready got=%b exp=1", k, req_ready); end
`ifdef TX_ERR_RESP_EN
            total++; if (dec_err !== 1'b1) begin bad++; $display("FAIL inv%0d_dec_err got=%b exp=1", k, dec_err); end
            total++; if (op_id !== ops[k]) begin bad++; $display("FAIL inv%0d_op got=%h exp=%h", k, op_id, ops[k]); end
            last_op = ops[k];
`else
            total++; if (op_id !== last_op) begin bad++; $display("FAIL inv%0d_op_hold got=%h exp=%h", k, op_id, last_op); end
`endif
            tick;
            total++; if (sel_en !== 5'b0) begin bad++; $display("FAIL inv%0d_after got=%b exp=00000", k, sel_en); end
`ifdef TX_ERR_RESP_EN
            total++; if (dec_err !== 1'b0) begin bad++; $display("FAIL inv%0d_dec_len got=%b exp=0", k, dec_err); end
`endif
        end
    endtask

    task automatic test_reset_mid;
        sw_busy = 5'b01000;
        drive_req(8'h30, 1'b1, 8'h5A, 8'h33);
        tick;
        req_valid = 1'b0;
        tick; tick;
        total++; if (req_ready !== 1'b0 || sel_en !== 5'b0) begin bad++; $display("FAIL rstmid_hold got=ready %b sel %b exp=0/00000", req_ready, sel_en); end
        rst_n = 1'b0;
        #1;
        total++; if (req_ready !== 1'b0 || sel_en !== 5'b0) begin bad++; $display("FAIL rstmid_ctrl got=ready %b sel %b exp=0/00000", req_ready, sel_en); end
        total++; if ({op_id, sw_addr, sw_wr, sw_wdata} !== 21'h0) begin bad++; $display("FAIL rstmid_payload got=%h/%h/%b/%h exp=0", op_id, sw_addr, sw_wr, sw_wdata); end
        tick;
        rst_n = 1'b1;
        sw_busy = '0;
        for (int i = 0; i < 6; i++) begin
            tick;
            total++; if (sel_en !== 5'b0 || req_ready !== 1'b1) begin bad++; $display("FAIL rstmid_stale%0d got=sel %b ready %b exp=00000/1", i, sel_en, req_ready); end
`ifdef TX_ERR_RESP_EN
            total++; if (dec_err !== 1'b0) begin bad++; $display("FAIL rstmid_dec%0d got=%b exp=0", i, dec_err); end
`endif
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset;
        test_basic_read;
        test_other_busy;
        test_blocked;
        test_back_to_back;
        test_shadow_gap;
        test_invalid;
        test_reset_mid;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
